urv_fetch: RTL and testbench

URV_FETCH -- requirements
Module: urv_fetch

---
 rtl/urv_fetch.sv | 147 ++++++++++++++
 tb/tb_urv_fetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_fetch.sv
// Instruction fetch unit: single-outstanding word fetch, halfword-aligned PC,
// compressed/uncompressed split with a one-entry stall buffer.
module urv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] im_addr_o,
    output logic        im_rd_o,
    input  logic [31:0] im_data_i,
    input  logic        im_valid_i,
    input  logic        f_stall_i,
    input  logic        f_kill_i,
    input  logic        x_bra_i,
    input  logic [31:0] x_bra_target_i,
    output logic [31:0] f_ir_o,
    output logic [31:0] f_pc_o,
    output logic        f_valid_o,
    output logic        f_is_compressed_o
);
    localparam logic [31:0] FETCH_RESET = RESET_VECTOR & ~32'h3;

    logic [31:0] pc, fa, rb;
    logic [15:0] hb;
    logic        hb_v, rb_v, drop, outstanding;

    logic [31:0] nxt_pc, nxt_fa, nxt_rb;
    logic [15:0] nxt_hb;
    logic        nxt_hb_v, nxt_rb_v, nxt_drop, nxt_out;
    logic        resp, live, have_w, hb_only, needs_mem, issue;
    logic [31:0] w;
    logic        emit, emit_c;
    logic [31:0] emit_ir;

    // A response is only meaningful while a request is in flight; drop discards it
    assign resp    = im_valid_i && outstanding;
    assign live    = resp && !drop;
    assign w       = rb_v ? rb : im_data_i;
    assign have_w  = rb_v || live;
    assign hb_only = pc[1] && hb_v && (hb[1:0] != 2'b11);

    always_comb begin
        nxt_pc   = pc;
        nxt_fa   = fa;
        nxt_hb   = hb;
        nxt_hb_v = hb_v;
        nxt_rb   = rb;
        nxt_rb_v = rb_v;
        nxt_drop = drop && !resp;
        nxt_out  = outstanding && !resp;
        emit     = 1'b0;
        emit_c   = 1'b0;
        emit_ir  = 32'h0;
        if (x_bra_i) begin
            nxt_pc   = x_bra_target_i & ~32'h1;
            nxt_fa   = x_bra_target_i & ~32'h3;
            nxt_hb_v = 1'b0;
            nxt_rb_v = 1'b0;
            nxt_drop = outstanding && !im_valid_i;
        end else if (f_stall_i) begin
            if (live) begin
                nxt_rb   = im_data_i;
                nxt_rb_v = 1'b1;
            end
        end else if (hb_only) begin
            emit     = 1'b1;
            emit_c   = 1'b1;
            emit_ir  = {16'h0, hb};
            nxt_pc   = pc + 32'd2;
            nxt_hb_v = 1'b0;
            if (live) begin
                nxt_rb   = im_data_i;
                nxt_rb_v = 1'b1;
            end
        end else if (have_w) begin
            nxt_rb_v = 1'b0;
            nxt_hb   = w[31:16];
            if (!pc[1]) begin
                emit = 1'b1;
                if (w[1:0] != 2'b11) begin
                    emit_c   = 1'b1;
                    emit_ir  = {16'h0, w[15:0]};
                    nxt_pc   = pc + 32'd2;
                    nxt_hb_v = 1'b1;
                end else begin
                    emit_ir  = w;
                    nxt_pc   = pc + 32'd4;
                    nxt_hb_v = 1'b0;
                end
            end else if (hb_v) begin
                // 32-bit instruction straddling two words
                emit     = 1'b1;
                emit_ir  = {w[15:0], hb};
                nxt_pc   = pc + 32'd4;
                nxt_hb_v = 1'b1;
            end else begin
                nxt_hb_v = 1'b1;
            end
        end
    end

    // Fetch only when the next decode step cannot be satisfied from hb alone
    assign needs_mem = !(nxt_pc[1] && nxt_hb_v && (nxt_hb[1:0] != 2'b11));
    assign issue     = !nxt_out && !nxt_rb_v && !nxt_drop && !f_stall_i && needs_mem;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc                <= RESET_VECTOR;
            fa                <= FETCH_RESET;
            hb                <= 16'h0;
            hb_v              <= 1'b0;
            rb                <= 32'h0;
            rb_v              <= 1'b0;
            drop              <= 1'b0;
            outstanding       <= 1'b0;
            im_rd_o           <= 1'b0;
            im_addr_o         <= 32'h0;
            f_valid_o         <= 1'b0;
            f_ir_o            <= 32'h0;
            f_pc_o            <= 32'h0;
            f_is_compressed_o <= 1'b0;
        end else begin
            pc          <= nxt_pc;
            hb          <= nxt_hb;
            hb_v        <= nxt_hb_v;
            rb          <= nxt_rb;
            rb_v        <= nxt_rb_v;
            drop        <= nxt_drop;
            outstanding <= nxt_out || issue;
            fa          <= issue ? nxt_fa + 32'd4 : nxt_fa;
            im_rd_o     <= issue;
            if (issue) begin
                im_addr_o <= nxt_fa;
            end
            if (x_bra_i || f_kill_i) begin
                f_valid_o <= 1'b0;
            end else if (!f_stall_i) begin
                f_valid_o <= emit;
            end
            if (emit) begin
                f_ir_o            <= emit_ir;
                f_pc_o            <= pc;
                f_is_compressed_o <= emit_c;
            end
        end
    end
endmodule

// File: tb/tb_urv_fetch.sv
// Directed bench for urv_fetch: table of straight-line streams plus branch,
// stall, kill, wrap and reset sequences against a latency-programmable memory.
module tb_urv_fetch;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] im_addr_o;
    logic        im_rd_o;
    logic [31:0] im_data_i = 32'h0;
    logic        im_valid_i = 1'b0;
    logic        f_stall_i = 1'b0;
    logic        f_kill_i = 1'b0;
    logic        x_bra_i = 1'b0;
    logic [31:0] x_bra_target_i = 32'h0;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;
    logic        f_valid_o;
    logic        f_is_compressed_o;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int cnt = 0;
    int n_reads = 0;
    logic [6:0]  raddr = 7'h0;
    logic [31:0] mem [128];

    urv_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .im_addr_o(im_addr_o), .im_rd_o(im_rd_o),
        .im_data_i(im_data_i), .im_valid_i(im_valid_i),
        .f_stall_i(f_stall_i), .f_kill_i(f_kill_i),
        .x_bra_i(x_bra_i), .x_bra_target_i(x_bra_target_i),
        .f_ir_o(f_ir_o), .f_pc_o(f_pc_o), .f_valid_o(f_valid_o),
        .f_is_compressed_o(f_is_compressed_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory: request seen in cycle C answers in cycle C+lat
    always @(negedge clk_i) begin
        im_valid_i = 1'b0;
        if (!rst_i) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    im_valid_i = 1'b1;
                    im_data_i  = mem[raddr];
                end
            end
            if (im_rd_o) begin
                cnt   = lat;
                raddr = im_addr_o[8:2];
            end
        end
    end

    always @(posedge clk_i) begin
        if (rst_i && im_rd_o) n_reads++;
    end

    typedef struct {
        string       name;
        logic [31:0] w0, w1, w2;
        int          lat;
        int          reads1;
        logic [31:0] pc [3];
        logic [31:0] ir [3];
        logic        c  [3];
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        f_stall_i = 1'b0;
        f_kill_i = 1'b0;
        x_bra_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic wait_instr(input string nm, input logic [31:0] epc,
                              input logic [31:0] eir, input logic ec);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!f_valid_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        if (!f_valid_o) begin
            checks++;
            failures++;
            $display("FAIL %s: no valid instruction within budget, expected pc %h", nm, epc);
        end else begin
            chk({nm, "_pc"}, f_pc_o, epc);
            chk({nm, "_ir"}, f_ir_o, eir);
            chk({nm, "_c"}, 32'(f_is_compressed_o), 32'(ec));
        end
    endtask

    task automatic wait_rd(input string nm, input logic [31:0] eaddr);
        int n;
        n = 0;
        while (!im_rd_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        if (!im_rd_o) begin
            checks++;
            failures++;
            $display("FAIL %s: no read request within budget, expected addr %h", nm, eaddr);
        end else begin
            chk(nm, im_addr_o, eaddr);
        end
    endtask

    task automatic set_vec(input int i, input string nm, input logic [31:0] w0, w1, w2,
                           input int l, input int r1,
                           input logic [31:0] p0, i0, input logic c0,
                           input logic [31:0] p1, i1, input logic c1,
                           input logic [31:0] p2, i2, input logic c2);
        vt[i].name = nm; vt[i].w0 = w0; vt[i].w1 = w1; vt[i].w2 = w2;
        vt[i].lat = l; vt[i].reads1 = r1;
        vt[i].pc[0] = p0; vt[i].ir[0] = i0; vt[i].c[0] = c0;
        vt[i].pc[1] = p1; vt[i].ir[1] = i1; vt[i].c[1] = c1;
        vt[i].pc[2] = p2; vt[i].ir[2] = i2; vt[i].c[2] = c2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        set_vec(0, "rv32", 32'h0000_0013, 32'h0010_0093, 32'h0000_0013, 1, 2,
                32'h0, 32'h0000_0013, 1'b0, 32'h4, 32'h0010_0093, 1'b0, 32'h8, 32'h0000_0013, 1'b0);
        set_vec(1, "two_rvc", 32'h00A5_0505, 32'h0000_0013, 32'h0000_0013, 2, 1,
                32'h0, 32'h0000_0505, 1'b1, 32'h2, 32'h0000_00A5, 1'b1, 32'h4, 32'h0000_0013, 1'b0);
        set_vec(2, "straddle", 32'h0013_4505, 32'hABCD_0000, 32'h0000_0013, 1, 2,
                32'h0, 32'h0000_4505, 1'b1, 32'h2, 32'h0000_0013, 1'b0, 32'h6, 32'h0000_ABCD, 1'b1);
        set_vec(3, "mixed", 32'h0010_0093, 32'h8082_4505, 32'h0000_0013, 3, 2,
                32'h0, 32'h0010_0093, 1'b0, 32'h4, 32'h0000_4505, 1'b1, 32'h6, 32'h0000_8082, 1'b1);
        set_vec(4, "nops", 32'h0001_0001, 32'h0000_0013, 32'h0000_0013, 1, 1,
                32'h0, 32'h0000_0001, 1'b1, 32'h2, 32'h0000_0001, 1'b1, 32'h4, 32'h0000_0013, 1'b0);

        clear_mem();
        #1;
        chk("reset_rd", 32'(im_rd_o), 32'h0);
        chk("reset_valid", 32'(f_valid_o), 32'h0);
        chk("reset_addr", im_addr_o, 32'h0);

        for (int v = 0; v < 5; v++) begin
            clear_mem();
            mem[0] = vt[v].w0;
            mem[1] = vt[v].w1;
            mem[2] = vt[v].w2;
            lat = vt[v].lat;
            do_reset();
            base = n_reads;
            for (int k = 0; k < 3; k++) begin
                wait_instr($sformatf("%s_i%0d", vt[v].name, k), vt[v].pc[k], vt[v].ir[k], vt[v].c[k]);
                if (k == 1) chk({vt[v].name, "_reads"}, 32'(n_reads - base), 32'(vt[v].reads1));
            end
        end

        // Branch to 0x103 while the word-0 request is in flight
        clear_mem();
        mem[64] = 32'h4505_0000;
        mem[65] = 32'h0000_0013;
        lat = 4;
        do_reset();
        @(negedge clk_i);
        wait_rd("bra_first_rd", 32'h0);
        @(negedge clk_i);
        x_bra_i = 1'b1;
        x_bra_target_i = 32'h0000_0103;
        @(negedge clk_i);
        x_bra_i = 1'b0;
        wait_rd("bra_rd", 32'h0000_0100);
        wait_instr("bra_i0", 32'h0000_0102, 32'h0000_4505, 1'b1);
        wait_instr("bra_i1", 32'h0000_0104, 32'h0000_0013, 1'b0);

        // Stall across a response, then kill
        clear_mem();
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        lat = 1;
        do_reset();
        wait_instr("stall_i0", 32'h0, 32'h0000_0013, 1'b0);
        wait_rd("stall_rd", 32'h4);
        f_stall_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk_i);
            chk($sformatf("stall_hold_pc%0d", s), f_pc_o, 32'h0);
            chk($sformatf("stall_hold_v%0d", s), 32'(f_valid_o), 32'h1);
            chk($sformatf("stall_no_rd%0d", s), 32'(im_rd_o), 32'h0);
        end
        f_stall_i = 1'b0;
        @(negedge clk_i);
        chk("stall_out_v", 32'(f_valid_o), 32'h1);
        chk("stall_out_pc", f_pc_o, 32'h4);
        chk("stall_out_ir", f_ir_o, 32'h0010_0093);
        f_kill_i = 1'b1;
        @(negedge clk_i);
        f_kill_i = 1'b0;
        chk("kill_v", 32'(f_valid_o), 32'h0);
        wait_instr("kill_next", 32'h8, 32'h0020_0113, 1'b0);

        // Branch at reset release to the top word: fetch address wraps to 0
        clear_mem();
        mem[127] = 32'h0000_0013;
        mem[0]   = 32'h0010_0093;
        lat = 2;
        do_reset();
        x_bra_i = 1'b1;
        x_bra_target_i = 32'hFFFF_FFFC;
        @(negedge clk_i);
        x_bra_i = 1'b0;
        wait_rd("wrap_rd", 32'hFFFF_FFFC);
        wait_instr("wrap_i0", 32'hFFFF_FFFC, 32'h0000_0013, 1'b0);
        wait_instr("wrap_i1", 32'h0, 32'h0010_0093, 1'b0);

        // Reset pulsed mid-stream
        clear_mem();
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        lat = 2;
        do_reset();
        wait_instr("mid_i0", 32'h0, 32'h0000_0013, 1'b0);
        wait_instr("mid_i1", 32'h4, 32'h0010_0093, 1'b0);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(f_valid_o), 32'h0);
        chk("mid_rst_pc", f_pc_o, 32'h0);
        chk("mid_rst_ir", f_ir_o, 32'h0);
        chk("mid_rst_c", 32'(f_is_compressed_o), 32'h0);
        chk("mid_rst_rd", 32'(im_rd_o), 32'h0);
        chk("mid_rst_addr", im_addr_o, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid_first_rd", 32'(im_rd_o), 32'h1);
        chk("mid_first_addr", im_addr_o, 32'h0);
        wait_instr("mid_after", 32'h0, 32'h0000_0013, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
